// File: rtl/count1s_pipe.sv
// Two-stage pipelined hit counter across NLAYERS layers with thresholds and a
// sliding-window occupancy sum. Optional peak tracker enabled by COUNT1S_PEAK_EN.
module count1s_pipe #(
  parameter int WIDTH   = 32,
  parameter int NLAYERS = 6,
  parameter int WINDOW  = 8,
  parameter int CNT_W   = $clog2(NLAYERS*WIDTH+1),
  parameter int LYR_W   = $clog2(NLAYERS+1),
  parameter int SUM_W   = CNT_W+$clog2(WINDOW)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     valid_in,
  input  logic [NLAYERS*WIDTH-1:0] din,
  input  logic [CNT_W-1:0]         hit_thresh,
  input  logic [LYR_W-1:0]         lyr_thresh,
  input  logic                     win_clr,
  output logic                     valid_out,
  output logic [CNT_W-1:0]         count,
  output logic [LYR_W-1:0]         nlyr,
  output logic                     over_hit,
  output logic                     over_lyr,
  output logic [SUM_W-1:0]         win_sum,
  output logic                     win_full
`ifdef COUNT1S_PEAK_EN
  ,
  input  logic                     peak_clr,
  output logic [CNT_W-1:0]         peak
`endif
);

  localparam int LC_W   = $clog2(WIDTH+1);
  localparam int PTR_W  = $clog2(WINDOW);
  localparam int FILL_W = $clog2(WINDOW+1);

  // ---------------- stage 1: per-layer popcount and OR ----------------
  logic [LC_W-1:0]    lcnt_next [NLAYERS];
  logic [LC_W-1:0]    lcnt_reg  [NLAYERS];
  logic [NLAYERS-1:0] lor_next;
  logic [NLAYERS-1:0] lor_reg;
  logic               valid_s1_reg;
  logic [CNT_W-1:0]   hit_thresh_reg;
  logic [LYR_W-1:0]   lyr_thresh_reg;

  generate
    for (genvar gi = 0; gi < NLAYERS; gi++) begin : g_layer
      logic [LC_W-1:0] layer_cnt;
      always_comb begin
        layer_cnt = '0;
        for (int b = 0; b < WIDTH; b++) begin
          layer_cnt = layer_cnt + LC_W'(din[gi*WIDTH + b]);
        end
      end
      // Disabled samples still flow through, but with all hits masked.
      assign lcnt_next[gi] = enable ? layer_cnt : '0;
      assign lor_next[gi]  = enable & (|din[gi*WIDTH +: WIDTH]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_s1_reg   <= 1'b0;
      lor_reg        <= '0;
      hit_thresh_reg <= '0;
      lyr_thresh_reg <= '0;
      for (int l = 0; l < NLAYERS; l++) lcnt_reg[l] <= '0;
    end else begin
      valid_s1_reg   <= valid_in;
      lor_reg        <= lor_next;
      hit_thresh_reg <= hit_thresh;
      lyr_thresh_reg <= lyr_thresh;
      for (int l = 0; l < NLAYERS; l++) lcnt_reg[l] <= lcnt_next[l];
    end
  end

  // ---------------- stage 2: totals and thresholds ----------------
  logic [CNT_W-1:0] cnt_sum;
  logic [LYR_W-1:0] lyr_sum;

  always_comb begin
    cnt_sum = '0;
    lyr_sum = '0;
    for (int l = 0; l < NLAYERS; l++) begin
      cnt_sum = cnt_sum + CNT_W'(lcnt_reg[l]);
      lyr_sum = lyr_sum + LYR_W'(lor_reg[l]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_out <= 1'b0;
      count     <= '0;
      nlyr      <= '0;
      over_hit  <= 1'b0;
      over_lyr  <= 1'b0;
    end else begin
      valid_out <= valid_s1_reg;
      if (valid_s1_reg) begin
        count    <= cnt_sum;
        nlyr     <= lyr_sum;
        over_hit <= (cnt_sum >= hit_thresh_reg);
        over_lyr <= (lyr_sum >= lyr_thresh_reg);
      end
    end
  end

  // ---------------- sliding window ----------------
  logic [CNT_W-1:0]  win_buf [WINDOW];
  logic [PTR_W-1:0]  ptr_reg;
  logic [FILL_W-1:0] fill_reg;
  logic [CNT_W-1:0]  oldest;
  logic              win_update;

  assign win_full   = (fill_reg == FILL_W'(WINDOW));
  assign win_update = valid_out & ~win_clr;
  // Entries are only read once the window has filled, so every entry read has
  // been rewritten since the last reset or clear; no buffer reset is needed.
  assign oldest     = win_full ? win_buf[ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n || win_clr) begin
      win_sum  <= '0;
      ptr_reg  <= '0;
      fill_reg <= '0;
    end else if (valid_out) begin
      win_sum <= win_sum + SUM_W'(count) - SUM_W'(oldest);
      ptr_reg <= ptr_reg + PTR_W'(1);
      if (!win_full) fill_reg <= fill_reg + FILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && win_update) win_buf[ptr_reg] <= count;
  end

`ifdef COUNT1S_PEAK_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      peak <= '0;
    end else if (peak_clr) begin
      peak <= valid_out ? count : '0;
    end else if (valid_out && (count > peak)) begin
      peak <= count;
    end
  end
`endif

endmodule

// File: tb/tb_count1s_pipe.sv
// Directed bench for count1s_pipe at default parameters; covers the peak
// tracker too when COUNT1S_PEAK_EN is defined.
module tb_count1s_pipe;
  localparam int WIDTH   = 32;
  localparam int NLAYERS = 6;
  localparam int WINDOW  = 8;
  localparam int CNT_W   = 8;
  localparam int LYR_W   = 3;
  localparam int SUM_W   = 11;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     enable;
  logic                     valid_in;
  logic [NLAYERS*WIDTH-1:0] din;
  logic [CNT_W-1:0]         hit_thresh;
  logic [LYR_W-1:0]         lyr_thresh;
  logic                     win_clr;
  logic                     valid_out;
  logic [CNT_W-1:0]         count;
  logic [LYR_W-1:0]         nlyr;
  logic                     over_hit;
  logic                     over_lyr;
  logic [SUM_W-1:0]         win_sum;
  logic                     win_full;
`ifdef COUNT1S_PEAK_EN
  logic                     peak_clr;
  logic [CNT_W-1:0]         peak;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int exp_sum [12] = '{1, 3, 6, 10, 15, 21, 28, 36, 44, 52, 60, 68};

  always #5 clk = ~clk;

  count1s_pipe #(
    .WIDTH(WIDTH), .NLAYERS(NLAYERS), .WINDOW(WINDOW),
    .CNT_W(CNT_W), .LYR_W(LYR_W), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .valid_in(valid_in),
    .din(din), .hit_thresh(hit_thresh), .lyr_thresh(lyr_thresh),
    .win_clr(win_clr), .valid_out(valid_out), .count(count), .nlyr(nlyr),
    .over_hit(over_hit), .over_lyr(over_lyr), .win_sum(win_sum),
    .win_full(win_full)
`ifdef COUNT1S_PEAK_EN
    , .peak_clr(peak_clr), .peak(peak)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) begin
      $display("ok   %-14s observed %0d expected %0d", tag, obs, exp);
    end else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ones(input int k);
    din = '0;
    for (int b = 0; b < k; b++) din[b] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b1;
    valid_in   = 1'b1;
    hit_thresh = '0;
    lyr_thresh = '0;
    win_clr    = 1'b0;
    din        = '0;
`ifdef COUNT1S_PEAK_EN
    peak_clr   = 1'b0;
`endif
    // Reset held for three cycles with random data presented.
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < NLAYERS; w++) din[w*WIDTH +: WIDTH] = $urandom();
      tick();
    end
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_nlyr", 32'(nlyr), 32'd0);
    check("rst_over_hit", 32'(over_hit), 32'd0);
    check("rst_over_lyr", 32'(over_lyr), 32'd0);
    check("rst_win_sum", 32'(win_sum), 32'd0);
    check("rst_win_full", 32'(win_full), 32'd0);
`ifdef COUNT1S_PEAK_EN
    check("rst_peak", 32'(peak), 32'd0);
`endif

    reset_n  = 1'b1;
    valid_in = 1'b0;
    tick();
    check("idle_valid", 32'(valid_out), 32'd0);

    // Full hits, latency 2.
    din = '1; hit_thresh = 8'd192; lyr_thresh = 3'd6; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check("full_lat1", 32'(valid_out), 32'd0);
    tick();
    check("full_valid", 32'(valid_out), 32'd1);
    check("full_count", 32'(count), 32'd192);
    check("full_nlyr", 32'(nlyr), 32'd6);
    check("full_over_hit", 32'(over_hit), 32'd1);
    check("full_over_lyr", 32'(over_lyr), 32'd1);
    tick();
    check("hold_valid", 32'(valid_out), 32'd0);
    check("hold_count", 32'(count), 32'd192);
    check("full_win_sum", 32'(win_sum), 32'd192);
    check("full_win_full", 32'(win_full), 32'd0);

    // Sparse hits, then the same data with enable low.
    din = '0; din[0] = 1'b1; din[96] = 1'b1; din[127] = 1'b1;
    hit_thresh = 8'd4; lyr_thresh = 3'd3; valid_in = 1'b1;
    tick();
    enable = 1'b0; hit_thresh = 8'd0; lyr_thresh = 3'd0;
    tick();
    check("sparse_valid", 32'(valid_out), 32'd1);
    check("sparse_count", 32'(count), 32'd3);
    check("sparse_nlyr", 32'(nlyr), 32'd2);
    check("sparse_over_hit", 32'(over_hit), 32'd0);
    check("sparse_over_lyr", 32'(over_lyr), 32'd0);
    valid_in = 1'b0; enable = 1'b1;
    tick();
    check("dis_valid", 32'(valid_out), 32'd1);
    check("dis_count", 32'(count), 32'd0);
    check("dis_nlyr", 32'(nlyr), 32'd0);
    check("dis_over_hit", 32'(over_hit), 32'd1);
    check("dis_over_lyr", 32'(over_lyr), 32'd1);
    check("sparse_win_sum", 32'(win_sum), 32'd195);
    // Clear coincides with the window update of the disabled sample.
    win_clr = 1'b1;
    tick();
    win_clr = 1'b0;
    check("clr1_win_sum", 32'(win_sum), 32'd0);
    check("clr1_win_full", 32'(win_full), 32'd0);

    // Back-to-back counts 1..12.
    hit_thresh = 8'd6; lyr_thresh = 3'd1;
    for (int c = 1; c <= 14; c++) begin
      if (c <= 12) begin
        set_ones(c);
        valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      tick();
      if (c >= 2 && c <= 13) begin
        check("b2b_count", 32'(count), 32'(c-1));
        check("b2b_over_hit", 32'(over_hit), 32'(c-1 >= 6));
      end
      if (c >= 3) begin
        check("b2b_win_sum", 32'(win_sum), 32'(exp_sum[c-3]));
        check("b2b_win_full", 32'(win_full), 32'(c-2 >= 8));
      end
    end

    // Clear while full, simultaneous with an update of count 4.
    set_ones(4); valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    win_clr = 1'b1;
    tick();
    win_clr = 1'b0;
    check("clr2_win_sum", 32'(win_sum), 32'd0);
    check("clr2_win_full", 32'(win_full), 32'd0);
    set_ones(5); valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    check("post_clr_sum", 32'(win_sum), 32'd5);
    check("post_clr_full", 32'(win_full), 32'd0);

`ifdef COUNT1S_PEAK_EN
    check("peak_before", 32'(peak), 32'd192);
    peak_clr = 1'b1;
    tick();
    peak_clr = 1'b0;
    check("peak_cleared", 32'(peak), 32'd0);
    set_ones(10); valid_in = 1'b1;
    tick();
    set_ones(50);
    tick();
    set_ones(20);
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    tick();
    check("peak_max", 32'(peak), 32'd50);
    set_ones(7); valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    peak_clr = 1'b1;
    tick();
    peak_clr = 1'b0;
    check("peak_clr_load", 32'(peak), 32'd7);
`endif

    // Reset while a sample is in flight.
    set_ones(9); valid_in = 1'b1;
    tick();
    valid_in = 1'b0; reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_sum", 32'(win_sum), 32'd0);
    tick();
    check("mid_rst_valid2", 32'(valid_out), 32'd0);
    tick();
    check("mid_rst_sum2", 32'(win_sum), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
